// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master and its receive sampler.
package spi_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_rx_sampler.sv
// Negedge MISO shift register, LSB-first; one bit per falling SCLK while enabled.
// Zero latency beyond the sampling edge; no backpressure, the frame length bounds the shifts.
module spi_master_rx_sampler #(
    parameter int DATA_WIDTH = spi_pkg::DEF_DATA_WIDTH
) (
    input  logic                  SCLK,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  sdi,
    output logic [DATA_WIDTH-1:0] rx
);

    // Shift toward the LSB so the first received bit ends up in bit 0.
    always_ff @(negedge SCLK or posedge reset) begin
        if (reset)
            rx <= '0;
        else if (en)
            rx <= (rx >> 1) | (DATA_WIDTH'(sdi) << (DATA_WIDTH - 1));
    end

endmodule

// File: rtl/spi_master.sv
// SPI master: one DATA_WIDTH frame per accepted start, done pulse DATA_WIDTH cycles after accept.
// No queueing: start is ignored while busy or when slaveSel is out of range.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N_SLAVES   = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                        SCLK,
    input  logic                        reset,
    input  logic                        start,
    input  logic [sel_w(N_SLAVES)-1:0]  slaveSel,
    input  logic [DATA_WIDTH-1:0]       masterDataToSend,
    output logic [DATA_WIDTH-1:0]       masterDataReceived,
    output logic                        busy,
    output logic                        done,
    output logic [N_SLAVES-1:0]         CS,
    output logic                        MOSI,
    input  logic                        MISO
);

    localparam int SW    = sel_w(N_SLAVES);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [SW:0]      SLAVE_LIM = (SW + 1)'(N_SLAVES);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic                  sel_ok;
    logic                  cs_active;

    assign sel_ok    = ({1'b0, slaveSel} < SLAVE_LIM);
    assign cs_active = ~&CS;

    spi_master_rx_sampler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rx_sampler (
        .SCLK  (SCLK),
        .reset (reset),
        .en    (cs_active),
        .sdi   (MISO),
        .rx    (rx_sh)
    );

    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            gap_cnt            <= '0;
            tx_sh              <= '0;
            CS                 <= '1;
            MOSI               <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            masterDataReceived <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && sel_ok) begin
                        // Bit 0 goes out with the accept edge; tx_sh holds what remains.
                        MOSI  <= masterDataToSend[0];
                        tx_sh <= masterDataToSend >> 1;
                        CS    <= ~(N_SLAVES'(1) << slaveSel);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        CS                 <= '1;
                        MOSI               <= 1'b0;
                        masterDataReceived <= rx_sh;
                        done               <= 1'b1;
                        gap_cnt            <= '0;
                        state              <= GAP;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        MOSI  <= tx_sh[0];
                        tx_sh <= tx_sh >> 1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
